mem_port_arbiter: RTL

- Shares the single-port 1024 x 64 memory between NUM_CORES core requesters and one debug requester.
- Round-robin arbitration among the cores; the debug port takes exclusive ownership while debug_on is high.
- Sits between the core array and the memory interface. Drives mem_addr_out and mem_data_out, and consumes mem_data_in.

---
 rtl/mem_port_arbiter_if.sv | 38 +++
 rtl/mem_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Memory-side bus of the shared single-port RAM.
//   mem_en        : access strobe for this cycle
//   mem_we        : 1 = write, 0 = read (meaningful while mem_en=1)
//   mem_addr_out  : word address
//   mem_data_out  : write data
//   mem_data_in   : read data, returned by the RAM one cycle after a read
// Modports:
//   master : the arbiter (drives the access, consumes read data)
//   slave  : the RAM (consumes the access, returns read data)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 64
);
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr_out;
  logic [DW-1:0] mem_data_out;
  logic [DW-1:0] mem_data_in;

  modport master (
    output mem_en,
    output mem_we,
    output mem_addr_out,
    output mem_data_out,
    input  mem_data_in
  );

  modport slave (
    input  mem_en,
    input  mem_we,
    input  mem_addr_out,
    input  mem_data_out,
    output mem_data_in
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory between NUM_CORES core requesters (round-robin)
// and a debug requester that owns the port exclusively while debug_on is high.
//
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   core_req/we/addr/wdata: per-core request, held until core_gnt
//   core_gnt              : one-hot combinational grant
//   core_rvalid/core_rdata: one-hot read strobe and shared read data
//   debug_on              : debug ownership request
//   dbg_req/we/addr/wdata : debug request
//   dbg_gnt, dbg_rvalid   : debug grant and read strobe (data on core_rdata)
//   dbg_active            : high while the debug port owns the memory
//   mem                   : memory bus (mem_port_arbiter_if.master)
//   stat_grants/conflicts : statistics counters
//
// Optional feature macro: MEM_PORT_ARB_STATS_EN
//   defined   : stat_grants counts accepted requests, stat_conflicts counts
//               RUN cycles with two or more core requests (both wrap).
//   undefined : both outputs are tied to 0, no counter flops.
//
// Access timing (accepted in cycle t):
//   t+1 : mem_en=1 with registered we/addr/data of the winner
//   t+2 : rvalid for reads, core_rdata = mem_data_in
//
// States:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_RUN   | cores arbitrated round-robin
//   ST_DRAIN | debug requested, no grants, waiting for pipeline to empty
//   ST_DEBUG | debug port owns the memory, dbg_gnt = dbg_req
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int AW        = 10,
  parameter int DW        = 64
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic [NUM_CORES-1:0]    core_req,
  input  logic [NUM_CORES-1:0]    core_we,
  input  logic [NUM_CORES*AW-1:0] core_addr,
  input  logic [NUM_CORES*DW-1:0] core_wdata,
  output logic [NUM_CORES-1:0]    core_gnt,
  output logic [NUM_CORES-1:0]    core_rvalid,
  output logic [DW-1:0]           core_rdata,

  input  logic                    debug_on,
  input  logic                    dbg_req,
  input  logic                    dbg_we,
  input  logic [AW-1:0]           dbg_addr,
  input  logic [DW-1:0]           dbg_wdata,
  output logic                    dbg_gnt,
  output logic                    dbg_rvalid,
  output logic                    dbg_active,

  mem_port_arbiter_if.master      mem,

  output logic [31:0]             stat_grants,
  output logic [31:0]             stat_conflicts
);

  localparam int PW = $clog2(NUM_CORES);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DEBUG = 2'd2;

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        rr_idx;
  logic [PW:0]          rr_cand;
  logic                 rr_found;
  logic                 run_ok;
  logic                 core_acc;
  logic                 dbg_acc;
  logic                 pipe_empty;

  logic                 sel_we;
  logic [AW-1:0]        sel_addr;
  logic [DW-1:0]        sel_wdata;

  logic                 s1_dbg;
  logic [PW-1:0]        s1_idx;
  logic [NUM_CORES-1:0] s1_oh;
  logic                 s1_rd;

  // ---------------------------------------------------------------------------
  // Round-robin search: candidate k is (rr_ptr + k) mod NUM_CORES; the first
  // candidate with its request set wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      rr_cand = {1'b0, rr_ptr} + (PW+1)'(k);
      if (rr_cand >= (PW+1)'(NUM_CORES)) begin
        rr_cand = rr_cand - (PW+1)'(NUM_CORES);
      end
      for (int i = 0; i < NUM_CORES; i++) begin
        if (!rr_found && core_req[i] && (rr_cand == (PW+1)'(i))) begin
          rr_found = 1'b1;
          rr_idx   = PW'(i);
        end
      end
    end
  end

  // A rising debug_on suppresses core grants in the same cycle so the drain
  // never has to chase a freshly accepted access.
  assign run_ok   = (state == ST_RUN) && !debug_on;
  assign core_acc = run_ok && rr_found;
  assign dbg_acc  = (state == ST_DEBUG) && dbg_req;

  always_comb begin
    core_gnt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      core_gnt[i] = core_acc && (rr_idx == PW'(i));
    end
  end

  assign dbg_gnt    = dbg_acc;
  assign dbg_active = (state == ST_DEBUG);

  // ---------------------------------------------------------------------------
  // Winner request mux
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_we    = dbg_we;
    sel_addr  = dbg_addr;
    sel_wdata = dbg_wdata;
    if (state != ST_DEBUG) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (rr_idx == PW'(i)) begin
          sel_we    = core_we[i];
          sel_addr  = core_addr[i*AW +: AW];
          sel_wdata = core_wdata[i*DW +: DW];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // Stage 1 is the registered memory access, stage 2 the read strobe.
  assign pipe_empty = !mem.mem_en && !(|core_rvalid) && !dbg_rvalid;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (debug_on) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!debug_on)       state_nxt = ST_RUN;
        else if (pipe_empty) state_nxt = ST_DEBUG;
      end
      ST_DEBUG: begin
        if (!debug_on) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_RUN;
      rr_ptr <= '0;
    end else begin
      state <= state_nxt;
      // rr_ptr is only touched by core grants, so it survives a debug session.
      if (core_acc) begin
        rr_ptr <= (rr_idx == PW'(NUM_CORES-1)) ? '0 : rr_idx + PW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: registered memory access. Address and data hold while idle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem.mem_en       <= 1'b0;
      mem.mem_we       <= 1'b0;
      mem.mem_addr_out <= '0;
      mem.mem_data_out <= '0;
      s1_dbg           <= 1'b0;
      s1_idx           <= '0;
    end else begin
      mem.mem_en <= core_acc || dbg_acc;
      if (core_acc || dbg_acc) begin
        mem.mem_we       <= sel_we;
        mem.mem_addr_out <= sel_addr;
        mem.mem_data_out <= sel_wdata;
        s1_dbg           <= dbg_acc;
        s1_idx           <= rr_idx;
      end else begin
        mem.mem_we <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: read strobe. The RAM's own output register supplies the data in
  // the strobe cycle, so core_rdata is that register gated by the strobe
  // (reads 0 whenever no strobe is active, including out of reset).
  // ---------------------------------------------------------------------------
  assign s1_rd = mem.mem_en && !mem.mem_we;

  always_comb begin
    s1_oh = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      s1_oh[i] = (s1_idx == PW'(i));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_rvalid <= '0;
      dbg_rvalid  <= 1'b0;
    end else begin
      core_rvalid <= (s1_rd && !s1_dbg) ? s1_oh : '0;
      dbg_rvalid  <= s1_rd && s1_dbg;
    end
  end

  assign core_rdata = (|core_rvalid || dbg_rvalid) ? mem.mem_data_in : '0;

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef MEM_PORT_ARB_STATS_EN
  logic multi_req;

  // Clearing the lowest set bit leaves something only if two or more are set.
  assign multi_req = (core_req & (core_req - NUM_CORES'(1))) != '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_grants    <= '0;
      stat_conflicts <= '0;
    end else begin
      if (core_acc || dbg_acc) begin
        stat_grants <= stat_grants + 32'd1;
      end
      if ((state == ST_RUN) && multi_req) begin
        stat_conflicts <= stat_conflicts + 32'd1;
      end
    end
  end
`else
  assign stat_grants    = '0;
  assign stat_conflicts = '0;
`endif

endmodule
